// File: rtl/snake_render_pkg.sv
// Shared tile codes, FSM states and default colours for the snake frame renderer.
package snake_render_pkg;

    localparam logic [7:0] TILE_EMPTY = 8'd0;
    localparam logic [7:0] TILE_BODY  = 8'd1;
    localparam logic [7:0] TILE_HEAD  = 8'd2;
    localparam logic [7:0] TILE_FOOD  = 8'd3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    localparam logic [15:0] DEF_BG_COLOR   = 16'h0000;
    localparam logic [15:0] DEF_BODY_COLOR = 16'h07E0;
    localparam logic [15:0] DEF_HEAD_COLOR = 16'hFFE0;
    localparam logic [15:0] DEF_FOOD_COLOR = 16'hF800;
    localparam logic [15:0] DEF_ERR_COLOR  = 16'hF81F;
    localparam logic [15:0] GRID_COLOR     = 16'h4208;

endpackage

// File: rtl/snake_tile_palette.sv
// Combinational tile code + in-tile pixel position -> RGB565 colour.
// SNAKE_RENDER_GRID_EN draws grid lines on the first column/row of every tile.
module snake_tile_palette
    import snake_render_pkg::*;
#(
    parameter int          PXW        = 3,
    parameter int          PYW        = 4,
    parameter logic [15:0] BG_COLOR   = DEF_BG_COLOR,
    parameter logic [15:0] BODY_COLOR = DEF_BODY_COLOR,
    parameter logic [15:0] HEAD_COLOR = DEF_HEAD_COLOR,
    parameter logic [15:0] FOOD_COLOR = DEF_FOOD_COLOR,
    parameter logic [15:0] ERR_COLOR  = DEF_ERR_COLOR
) (
    input  logic [7:0]     code_i,
    input  logic [PXW-1:0] px_i,
    input  logic [PYW-1:0] py_i,
    output logic [15:0]    color_o
);

`ifdef SNAKE_RENDER_GRID_EN
    localparam bit GRID_EN = 1'b1;
`else
    localparam bit GRID_EN = 1'b0;
`endif

    // NOTE: color_o gets a value on every path through this block, otherwise a latch is inferred.
    always_comb begin
        case (code_i)
            TILE_EMPTY: color_o = BG_COLOR;
            TILE_BODY:  color_o = BODY_COLOR;
            TILE_HEAD:  color_o = HEAD_COLOR;
            TILE_FOOD:  color_o = FOOD_COLOR;
            default:    color_o = ERR_COLOR;
        endcase
        if (GRID_EN && (px_i == '0 || py_i == '0)) begin
            color_o = GRID_COLOR;
        end
    end

endmodule

// File: rtl/snake_frame_renderer.sv
// Streams the snake tile grid as one RGB565 raster frame; each tile row is refetched per pixel row.
// Build option SNAKE_RENDER_GRID_EN enables grid lines in snake_tile_palette.
module snake_frame_renderer
    import snake_render_pkg::*;
#(
    parameter int          GRID_COLS  = 40,
    parameter int          GRID_ROWS  = 19,
    parameter int          CELL_W     = 8,
    parameter int          CELL_H     = 12,
    parameter logic [15:0] BG_COLOR   = DEF_BG_COLOR,
    parameter logic [15:0] BODY_COLOR = DEF_BODY_COLOR,
    parameter logic [15:0] HEAD_COLOR = DEF_HEAD_COLOR,
    parameter logic [15:0] FOOD_COLOR = DEF_FOOD_COLOR,
    parameter logic [15:0] ERR_COLOR  = DEF_ERR_COLOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic [9:0]  mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    output logic        mem_write,
    input  logic [7:0]  mem_readdata,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_first,
    output logic        pix_last
);

    localparam int PXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int PYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int CLW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int RWW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

    localparam logic [PXW-1:0] PX_LAST  = PXW'(CELL_W - 1);
    localparam logic [PYW-1:0] PY_LAST  = PYW'(CELL_H - 1);
    localparam logic [CLW-1:0] COL_LAST = CLW'(GRID_COLS - 1);
    localparam logic [RWW-1:0] ROW_LAST = RWW'(GRID_ROWS - 1);
    localparam logic [9:0]     ROW_STEP = 10'(GRID_COLS);

    state_t         state_q;
    logic [PXW-1:0] px_q;
    logic [PYW-1:0] py_q;
    logic [CLW-1:0] col_q;
    logic [RWW-1:0] row_q;
    logic [9:0]     row_base_q;
    logic [9:0]     addr_q;
    logic [7:0]     tile_q;
    logic           busy_q, frame_done_q, cs_q, clken_q;
    logic [15:0]    pix_data_q;
    logic           pix_valid_q, pix_first_q, pix_last_q;

    logic           last_col, last_py, last_row, last_tile;
    logic [PXW-1:0] px_inc, pal_px;
    logic [7:0]     pal_code;
    logic [15:0]    pal_color;
    logic [9:0]     next_addr;

    // The palette looks at the fresh memory word in WAIT and at the stored tile in EMIT.
    always_comb begin
        last_col  = (col_q == COL_LAST);
        last_py   = (py_q == PY_LAST);
        last_row  = (row_q == ROW_LAST);
        last_tile = last_col && last_py && last_row;
        px_inc    = px_q + PXW'(1);
        pal_code  = (state_q == WAIT) ? mem_readdata : tile_q;
        pal_px    = (state_q == WAIT) ? '0 : px_inc;
        if (!last_col) begin
            next_addr = row_base_q + 10'(col_q) + 10'd1;
        end else if (!last_py) begin
            next_addr = row_base_q;
        end else begin
            next_addr = row_base_q + ROW_STEP;
        end
    end

    snake_tile_palette #(
        .PXW        (PXW),
        .PYW        (PYW),
        .BG_COLOR   (BG_COLOR),
        .BODY_COLOR (BODY_COLOR),
        .HEAD_COLOR (HEAD_COLOR),
        .FOOD_COLOR (FOOD_COLOR),
        .ERR_COLOR  (ERR_COLOR)
    ) u_palette (
        .code_i  (pal_code),
        .px_i    (pal_px),
        .py_i    (py_q),
        .color_o (pal_color)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            px_q         <= '0;
            py_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            addr_q       <= '0;
            tile_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cs_q         <= 1'b0;
            clken_q      <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_first_q  <= 1'b0;
            pix_last_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        cs_q       <= 1'b1;
                        clken_q    <= 1'b1;
                        addr_q     <= '0;
                        px_q       <= '0;
                        py_q       <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        row_base_q <= '0;
                    end
                end
                FETCH: begin
                    cs_q    <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    clken_q     <= 1'b0;
                    tile_q      <= mem_readdata;
                    px_q        <= '0;
                    pix_valid_q <= 1'b1;
                    pix_data_q  <= pal_color;
                    pix_first_q <= (row_q == '0) && (py_q == '0) && (col_q == '0);
                    pix_last_q  <= last_tile && (CELL_W == 1);
                    state_q     <= EMIT;
                end
                EMIT: begin
                    if (pix_ready) begin
                        if (px_q != PX_LAST) begin
                            px_q        <= px_inc;
                            pix_data_q  <= pal_color;
                            pix_first_q <= 1'b0;
                            pix_last_q  <= last_tile && (px_inc == PX_LAST);
                        end else begin
                            pix_valid_q <= 1'b0;
                            pix_first_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            if (last_tile) begin
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
                            end else begin
                                state_q <= FETCH;
                                cs_q    <= 1'b1;
                                clken_q <= 1'b1;
                                addr_q  <= next_addr;
                                if (!last_col) begin
                                    col_q <= col_q + CLW'(1);
                                end else begin
                                    col_q <= '0;
                                    if (!last_py) begin
                                        py_q <= py_q + PYW'(1);
                                    end else begin
                                        py_q       <= '0;
                                        row_q      <= row_q + RWW'(1);
                                        row_base_q <= row_base_q + ROW_STEP;
                                    end
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_clken      = clken_q;
    assign mem_write      = 1'b0;
    assign pix_data       = pix_data_q;
    assign pix_valid      = pix_valid_q;
    assign pix_first      = pix_first_q;
    assign pix_last       = pix_last_q;

endmodule
